// File: rtl/serial_tx9_if.sv
// Byte-producer to serial-transmitter handshake plus the line-side outputs.
// The producer uses the master modport; the transmitter uses the slave modport.
interface serial_tx9_if;
   logic [7:0] data_in;
   logic       start;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (
      output data_in,
      output start,
      input  ready,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  data_in,
      input  start,
      output ready,
      output tx,
      output busy,
      output done
   );
endinterface

// File: rtl/serial_tx9.sv
// LSB-first framed serial transmitter: start(0), D0..D7, parity, stop(1).
// Every line bit is held CLKS_PER_BIT clocks; all outputs come straight from flops.
module serial_tx9 #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_ODD   = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   serial_tx9_if.slave   bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [8:0]          shreg_q, shreg_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                accept_s;
   logic                baud_end_s;

   function automatic logic parity_of(input logic [7:0] data);
      parity_of = (^data) ^ PARITY_ODD;
   endfunction

   assign accept_s   = bus.start & ready_q;
   assign baud_end_s = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shreg_q <= 9'h1FF;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = 3'd0;
            if (accept_s) begin
               state_d = S_START;
               shreg_d = {parity_of(bus.data_in), bus.data_in};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (baud_end_s) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            // Shift at each bit end; after eight shifts shreg[0] holds parity.
            if (baud_end_s) begin
               baud_d  = '0;
               shreg_d = {1'b1, shreg_q[8:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = S_PARITY;
               end else begin
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         S_PARITY: begin
            if (baud_end_s) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_end_s) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = 3'd0;
            shreg_d = 9'h1FF;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with state_q.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
         S_START: begin
            tx_d   = 1'b0;
         end
         S_DATA, S_PARITY: begin
            tx_d   = shreg_d[0];
         end
         S_STOP: begin
            tx_d   = 1'b1;
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
      ready_d = ~busy_d;
      if ((state_q == S_STOP) && baud_end_s) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   assign bus.tx    = tx_q;
   assign bus.busy  = busy_q;
   assign bus.ready = ready_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_tx9.sv
// Randomized self-checking bench for serial_tx9: an odd-parity and an even-parity
// instance, both at 4 clocks per bit, checked against an expected-frame model.
module tb_serial_tx9;

   localparam int C = 4;

   logic       clk;
   logic       reset;
   logic [7:0] data_in_r;
   logic       start_r;
   logic       sel_r;          // 0 = odd-parity instance, 1 = even-parity instance
   int         n_checks;
   int         n_errors;

   serial_tx9_if if_o ();
   serial_tx9_if if_e ();

   assign if_o.data_in = data_in_r;
   assign if_e.data_in = data_in_r;
   assign if_o.start   = start_r & ~sel_r;
   assign if_e.start   = start_r &  sel_r;

   serial_tx9 #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) u_dut_odd (
      .clk   (clk),
      .reset (reset),
      .bus   (if_o)
   );

   serial_tx9 #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) u_dut_even (
      .clk   (clk),
      .reset (reset),
      .bus   (if_e)
   );

   logic tx_m, busy_m, ready_m, done_m;
   assign tx_m    = sel_r ? if_e.tx    : if_o.tx;
   assign busy_m  = sel_r ? if_e.busy  : if_o.busy;
   assign ready_m = sel_r ? if_e.ready : if_o.ready;
   assign done_m  = sel_r ? if_e.done  : if_o.done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Line image of one frame, index 0 = start bit, index 10 = stop bit.
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
      int   ones;
      logic par;
      ones = $countones(d);
      if ((ones % 2) == (odd ? 1 : 0)) par = 1'b0;
      else                             par = 1'b1;
      frame_bits = {1'b1, par, d, 1'b0};
   endfunction

   // Called at a negedge with the selected instance idle; returns at frame cycle 0.
   task automatic send_start(input logic [7:0] d);
      data_in_r = d;
      start_r   = 1'b1;
      @(negedge clk);
      start_r   = 1'b0;
      data_in_r = ~d;
   endtask

   // Checks one whole frame starting at the current negedge (frame cycle 0),
   // then the done cycle; optionally launches the next frame in the done cycle.
   task automatic check_frame(input logic [7:0] d, input bit inject,
                              input bit chain, input logic [7:0] nxt);
      logic [10:0] fb;
      fb = frame_bits(d, ~sel_r);
      for (int i = 0; i < 11 * C; i++) begin
         if (i > 0) @(negedge clk);
         check_eq($sformatf("tx d=%02h cyc=%0d", d, i), tx_m, fb[i / C]);
         check_eq($sformatf("busy d=%02h cyc=%0d", d, i), busy_m, 1'b1);
         check_eq($sformatf("ready d=%02h cyc=%0d", d, i), ready_m, 1'b0);
         check_eq($sformatf("done d=%02h cyc=%0d", d, i), done_m, 1'b0);
         if (inject && i == 4 * C + 1) begin
            data_in_r = 8'h55;
            start_r   = 1'b1;
         end else if (inject && i == 4 * C + 2) begin
            start_r   = 1'b0;
         end
      end
      @(negedge clk);
      check_eq($sformatf("done_pulse d=%02h", d), done_m, 1'b1);
      check_eq($sformatf("done_tx d=%02h", d), tx_m, 1'b1);
      check_eq($sformatf("done_ready d=%02h", d), ready_m, 1'b1);
      check_eq($sformatf("done_busy d=%02h", d), busy_m, 1'b0);
      if (chain) begin
         data_in_r = nxt;
         start_r   = 1'b1;
         @(negedge clk);
         start_r   = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_eq({tag, "_tx"}, tx_m, 1'b1);
         check_eq({tag, "_busy"}, busy_m, 1'b0);
         check_eq({tag, "_ready"}, ready_m, 1'b1);
         check_eq({tag, "_done"}, done_m, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] d, nd;
      bit         pending, chain;
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      start_r   = 1'b0;
      data_in_r = 8'h00;
      sel_r     = 1'b0;

      repeat (2) @(negedge clk);
      check_eq("rst_tx_o", if_o.tx, 1'b1);
      check_eq("rst_ready_o", if_o.ready, 1'b1);
      check_eq("rst_busy_o", if_o.busy, 1'b0);
      check_eq("rst_done_o", if_o.done, 1'b0);
      check_eq("rst_tx_e", if_e.tx, 1'b1);
      reset = 1'b0;

      // Idle with start low on both instances.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check_eq("idle_tx_o", if_o.tx, 1'b1);
         check_eq("idle_ready_o", if_o.ready, 1'b1);
         check_eq("idle_busy_o", if_o.busy, 1'b0);
         check_eq("idle_done_o", if_o.done, 1'b0);
         check_eq("idle_tx_e", if_e.tx, 1'b1);
         check_eq("idle_done_e", if_e.done, 1'b0);
      end

      // Odd parity, 0xA5.
      sel_r = 1'b0;
      send_start(8'hA5);
      check_frame(8'hA5, 1'b0, 1'b0, 8'h00);
      check_idle("post_a5", 3);

      // Even parity, 0x01 then 0xFF.
      sel_r = 1'b1;
      send_start(8'h01);
      check_frame(8'h01, 1'b0, 1'b0, 8'h00);
      check_idle("post_01", 2);
      send_start(8'hFF);
      check_frame(8'hFF, 1'b0, 1'b0, 8'h00);
      check_idle("post_ff", 2);

      // Back-to-back 0x3C then 0xC3 on the odd instance.
      sel_r = 1'b0;
      send_start(8'h3C);
      check_frame(8'h3C, 1'b0, 1'b1, 8'hC3);
      check_frame(8'hC3, 1'b0, 1'b0, 8'h00);
      check_idle("post_b2b", 3);

      // start with 0x55 while busy in DATA must be ignored.
      send_start(8'h0F);
      check_frame(8'h0F, 1'b1, 1'b0, 8'h00);
      check_idle("post_inject", 10);

      // Asynchronous reset during D3, then a fresh 0x81 frame.
      sel_r = 1'b0;
      send_start(8'hA5);
      repeat (4 * C + 1) @(negedge clk);
      check_eq("pre_rst_d3_tx", tx_m, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_tx", tx_m, 1'b1);
      check_eq("async_rst_ready", ready_m, 1'b1);
      check_eq("async_rst_busy", busy_m, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      check_idle("post_rst", 3);
      send_start(8'h81);
      check_frame(8'h81, 1'b0, 1'b0, 8'h00);
      check_idle("post_81", 2);

      // Random frames, random instance, random gaps and back-to-back chaining.
      pending = 1'b0;
      d       = 8'h00;
      for (int n = 0; n < 14; n++) begin
         if (!pending) begin
            d = 8'($urandom);
            check_idle("rnd_gap", $urandom_range(1, 4));
            sel_r = 1'($urandom_range(0, 1));
            send_start(d);
         end
         chain = (n < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
         nd    = 8'($urandom);
         check_frame(d, 1'($urandom_range(0, 1)), chain, nd);
         pending = chain;
         d       = nd;
      end
      check_idle("rnd_end", 5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_tx9.md
Name: serial_tx9

Overview:
- LSB-first serial transmitter; the transmit-side counterpart of the team's 9-bit right-shifting receive register.
- Serializes an 8-bit byte plus a computed parity bit into a framed line: start(0), D0..D7, parity, stop(1).
- Sits between a byte producer with a ready/start handshake and the single-wire serial output pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles each line bit is held; legal range 2..65535.
- PARITY_ODD, 1, 1 = odd parity (total ones in D0..D7 plus parity bit is odd); 0 = even parity.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to send; sampled only in the acceptance cycle.
- start  input  1  request to send data_in.
- ready  output  1  high when a start will be accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (async, immediate): tx=1, ready=1, busy=0, done=0, state IDLE, bit counter=0, baud counter=0. Reset mid-frame aborts the frame. tx returns high without waiting for a clock edge.
- Acceptance: on a rising edge with ready=1 and start=1:
  - latch {parity, data_in} into a 9-bit shift register.
  - parity = ^data_in XOR PARITY_ODD.
  - From the next cycle: state START, tx=0, busy=1, ready=0.
- start while ready=0 is ignored. No queuing; data_in changes after acceptance have no effect.
- States, each held exactly CLKS_PER_BIT cycles by a baud counter counting 0..CLKS_PER_BIT-1:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shreg[0]. At each bit end the register shifts right by 1, filling with 1. 8 bits are counted by the bit counter, 0..7.
  - PARITY: tx=shreg[0], which holds the parity bit after 8 shifts.
  - STOP: tx=1.
- Transitions: IDLE->START on accept; START->DATA; DATA->PARITY after bit 7; PARITY->STOP; STOP->IDLE.
- Frame length: exactly 11*CLKS_PER_BIT cycles from the first tx=0 cycle to the first cycle back in IDLE.
- Completion: in the last cycle of STOP, register done=1 for the following cycle. In that same following cycle, state=IDLE, ready=1, busy=0, tx=1.
- Back-to-back: start=1 in the cycle done=1 is accepted. The next start bit follows with exactly one idle-high cycle between frames.
- tx, ready, busy and done are driven from registers; none has a combinational path from the inputs.
- ready = ~busy at all times outside reset.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit counter is 3 bits. No wrap beyond terminal count.

Test Plan:
- Reset then idle 50 cycles with start=0 -> tx=1, ready=1, busy=0, done never asserted.
- CLKS_PER_BIT=4, PARITY_ODD=1, send 0xA5 -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1,1 (parity=1). done pulses once, 44 cycles after the first tx=0.
- PARITY_ODD=0, send 0x01 then 0xFF -> parity bits 1 then 0. Data bits LSB first: 1,0,0,0,0,0,0,0 and all ones.
- Back-to-back: hold start=1 with 0x3C, then 0xC3 issued in the done cycle -> second frame accepted. Exactly one idle-high cycle between frames; both frames bit-exact.
- start pulsed with 0x55 while busy in the DATA state -> ignored; the frame in flight is unchanged and no extra frame is sent.
- Assert reset during bit D3 of a frame -> tx=1 immediately (asynchronous), ready=1. After release, a new send of 0x81 produces a complete correct frame.
